// File: rtl/node_integrator_pkg.sv
//------------------------------------------------------------------------------
// Module : node_integrator_pkg
// Brief  : Shared physics constants, FSM encodings and the saturate helper.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package node_integrator_pkg;

    localparam int DEF_NUM_NODES     = 10;
    localparam int DEF_POSITION_SIZE = 8;
    localparam int DEF_VELOCITY_SIZE = 8;
    localparam int DEF_FORCE_SIZE    = 8;
    localparam int DEF_MASS_SHIFT    = 0;
    localparam int DEF_DT_SHIFT      = 2;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Clamp a wide signed value into the range of a WIDTH-bit signed number.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] val,
                                                    input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (val > hi) begin
            return hi;
        end
        if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/node_integrator_euler_step.sv
//------------------------------------------------------------------------------
// Module : euler_step
// Brief  : One-axis semi-implicit Euler update with saturating v and p.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module euler_step
    import node_integrator_pkg::*;
#(
    parameter int POSITION_SIZE = DEF_POSITION_SIZE,
    parameter int VELOCITY_SIZE = DEF_VELOCITY_SIZE,
    parameter int FORCE_SIZE    = DEF_FORCE_SIZE,
    parameter int MASS_SHIFT    = DEF_MASS_SHIFT,
    parameter int DT_SHIFT      = DEF_DT_SHIFT
) (
    input  logic signed [FORCE_SIZE-1:0]    force_i,
    input  logic signed [VELOCITY_SIZE-1:0] vel_i,
    input  logic signed [POSITION_SIZE-1:0] pos_i,
    output logic signed [VELOCITY_SIZE-1:0] vel_o,
    output logic signed [POSITION_SIZE-1:0] pos_o
);

    logic signed [31:0] accel_w;
    logic signed [31:0] vel_sum_w;
    logic signed [31:0] pos_sum_w;

    // Position advances with the already-updated velocity (semi-implicit).
    always_comb begin
        accel_w   = 32'(force_i) >>> MASS_SHIFT;
        vel_sum_w = 32'(vel_i) + (accel_w >>> DT_SHIFT);
        vel_o     = VELOCITY_SIZE'(saturate(vel_sum_w, VELOCITY_SIZE));
        pos_sum_w = 32'(pos_i) + (32'(vel_o) >>> DT_SHIFT);
        pos_o     = POSITION_SIZE'(saturate(pos_sum_w, POSITION_SIZE));
    end

endmodule

`default_nettype wire

// File: rtl/node_integrator.sv
//------------------------------------------------------------------------------
// Module : node_integrator
// Brief  : Integrates one force beat per node per frame into stored v/p arrays.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module node_integrator
    import node_integrator_pkg::*;
#(
    parameter int NUM_NODES     = DEF_NUM_NODES,
    parameter int POSITION_SIZE = DEF_POSITION_SIZE,
    parameter int VELOCITY_SIZE = DEF_VELOCITY_SIZE,
    parameter int FORCE_SIZE    = DEF_FORCE_SIZE,
    parameter int MASS_SHIFT    = DEF_MASS_SHIFT,
    parameter int DT_SHIFT      = DEF_DT_SHIFT
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            load_valid,
    input  logic signed [POSITION_SIZE-1:0] nodes_in       [2][NUM_NODES],
    input  logic signed [VELOCITY_SIZE-1:0] velocities_in  [2][NUM_NODES],
    input  logic signed [FORCE_SIZE-1:0]    force_x_in,
    input  logic signed [FORCE_SIZE-1:0]    force_y_in,
    input  logic                            force_in_valid,
    output logic signed [POSITION_SIZE-1:0] nodes_out      [2][NUM_NODES],
    output logic signed [VELOCITY_SIZE-1:0] velocities_out [2][NUM_NODES],
    output logic                            busy,
    output logic                            output_valid,
    output logic                            overrun
);

    localparam int             IDX_W    = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               overrun_q, overrun_d;

    logic signed [POSITION_SIZE-1:0] pos_q [2][NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] vel_q [2][NUM_NODES];

    logic signed [FORCE_SIZE-1:0]    force_w   [2];
    logic signed [POSITION_SIZE-1:0] cur_pos_w [2];
    logic signed [VELOCITY_SIZE-1:0] cur_vel_w [2];
    logic signed [POSITION_SIZE-1:0] new_pos_w [2];
    logic signed [VELOCITY_SIZE-1:0] new_vel_w [2];
    logic                            load_w;
    logic                            beat_w;

    assign force_w[0] = force_x_in;
    assign force_w[1] = force_y_in;
    assign load_w     = load_valid && (state_q == ST_IDLE);
    assign beat_w     = force_in_valid && ((state_q == ST_IDLE) || (state_q == ST_RUN));

    // A same-cycle load feeds the first beat directly so it integrates loaded values.
    always_comb begin
        for (int ax = 0; ax < 2; ax++) begin
            cur_pos_w[ax] = load_w ? nodes_in[ax][idx_q]      : pos_q[ax][idx_q];
            cur_vel_w[ax] = load_w ? velocities_in[ax][idx_q] : vel_q[ax][idx_q];
        end
    end

    for (genvar ax = 0; ax < 2; ax++) begin : g_axis
        euler_step #(
            .POSITION_SIZE (POSITION_SIZE),
            .VELOCITY_SIZE (VELOCITY_SIZE),
            .FORCE_SIZE    (FORCE_SIZE),
            .MASS_SHIFT    (MASS_SHIFT),
            .DT_SHIFT      (DT_SHIFT)
        ) u_step (
            .force_i (force_w[ax]),
            .vel_i   (cur_vel_w[ax]),
            .pos_i   (cur_pos_w[ax]),
            .vel_o   (new_vel_w[ax]),
            .pos_o   (new_pos_w[ax])
        );
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (force_in_valid) begin
                    idx_d   = IDX_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (force_in_valid) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (force_in_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            for (int ax = 0; ax < 2; ax++) begin
                for (int n = 0; n < NUM_NODES; n++) begin
                    pos_q[ax][n] <= '0;
                    vel_q[ax][n] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            if (load_w) begin
                pos_q <= nodes_in;
                vel_q <= velocities_in;
            end
            // Beat write comes after the bulk load so node 0 takes the integrated value.
            if (beat_w) begin
                for (int ax = 0; ax < 2; ax++) begin
                    pos_q[ax][idx_q] <= new_pos_w[ax];
                    vel_q[ax][idx_q] <= new_vel_w[ax];
                end
            end
        end
    end

    assign nodes_out      = pos_q;
    assign velocities_out = vel_q;
    assign busy           = (state_q == ST_RUN);
    assign output_valid   = (state_q == ST_DONE);
    assign overrun        = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_node_integrator.sv
//------------------------------------------------------------------------------
// Module : tb_node_integrator
// Brief  : Directed self-checking bench for node_integrator (4 nodes, dt=1/4).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_node_integrator;

    localparam int NN = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                load_valid = 1'b0;
    logic signed [7:0]   nodes_in      [2][NN];
    logic signed [7:0]   velocities_in [2][NN];
    logic signed [7:0]   force_x = '0;
    logic signed [7:0]   force_y = '0;
    logic                force_valid = 1'b0;
    logic signed [7:0]   nodes_out      [2][NN];
    logic signed [7:0]   velocities_out [2][NN];
    logic                busy;
    logic                output_valid;
    logic                overrun;

    int n_total = 0;
    int n_bad   = 0;

    node_integrator #(
        .NUM_NODES     (NN),
        .POSITION_SIZE (8),
        .VELOCITY_SIZE (8),
        .FORCE_SIZE    (8),
        .MASS_SHIFT    (0),
        .DT_SHIFT      (2)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .load_valid     (load_valid),
        .nodes_in       (nodes_in),
        .velocities_in  (velocities_in),
        .force_x_in     (force_x),
        .force_y_in     (force_y),
        .force_in_valid (force_valid),
        .nodes_out      (nodes_out),
        .velocities_out (velocities_out),
        .busy           (busy),
        .output_valid   (output_valid),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input int px, input int py, input int vx, input int vy);
        for (int n = 0; n < NN; n++) begin
            nodes_in[0][n]      = 8'(px);
            nodes_in[1][n]      = 8'(py);
            velocities_in[0][n] = 8'(vx);
            velocities_in[1][n] = 8'(vy);
        end
    endtask

    task automatic check_node(input string tag, input int n,
                              input int px, input int py, input int vx, input int vy);
        check_eq({tag, ".px"}, nodes_out[0][n], px);
        check_eq({tag, ".py"}, nodes_out[1][n], py);
        check_eq({tag, ".vx"}, velocities_out[0][n], vx);
        check_eq({tag, ".vy"}, velocities_out[1][n], vy);
    endtask

    task automatic do_load(input int px, input int py, input int vx, input int vy);
        set_load(px, py, vx, vy);
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        int beats;
        set_load(0, 0, 0, 0);

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check_eq("rst.busy", busy, 0);
        check_eq("rst.ovalid", output_valid, 0);
        check_eq("rst.overrun", overrun, 0);
        check_node("rst.n2", 2, 0, 0, 0, 0);

        // Basic step: p=(10,10), v=0, f=(16,-16) -> v=(4,-4), p=(11,9)
        do_load(10, 10, 0, 0);
        check_node("load.n3", 3, 10, 10, 0, 0);
        force_x = 8'sd16; force_y = -8'sd16;
        for (int k = 0; k < NN; k++) begin
            force_valid = 1'b1;
            tick();
            check_node("basic.nk", k, 11, 9, 4, -4);
            check_eq("basic.ovalid", output_valid, (k == NN - 1) ? 1 : 0);
            check_eq("basic.busy", busy, (k == NN - 1) ? 0 : 1);
            if (k < NN - 1) check_node("basic.next_held", k + 1, 10, 10, 0, 0);
        end
        force_valid = 1'b0;
        tick();
        check_eq("basic.ovalid_drop", output_valid, 0);
        check_eq("basic.idle_busy", busy, 0);

        // Saturation
        do_load(120, -120, 120, -120);
        force_x = 8'sd127; force_y = -8'sd128;
        force_valid = 1'b1;
        for (int k = 0; k < NN; k++) tick();
        force_valid = 1'b0;
        check_eq("sat.ovalid", output_valid, 1);
        check_node("sat.n0", 0, 127, -128, 127, -128);
        check_node("sat.n3", 3, 127, -128, 127, -128);
        tick();

        // Gaps: beats at cycles 0,3,4,9; f=(16,32) from zero -> v=(4,8), p=(1,2)
        do_load(0, 0, 0, 0);
        force_x = 8'sd16; force_y = 8'sd32;
        beats = 0;
        for (int c = 0; c < 10; c++) begin
            force_valid = (c == 0 || c == 3 || c == 4 || c == 9);
            if (force_valid) beats++;
            tick();
            check_eq("gap.busy", busy, (c < 9) ? 1 : 0);
            check_eq("gap.ovalid", output_valid, (c == 9) ? 1 : 0);
            check_eq("gap.done_vx", velocities_out[0][beats - 1], 4);
            check_eq("gap.done_py", nodes_out[1][beats - 1], 2);
            if (beats < NN) check_eq("gap.pend_vx", velocities_out[0][beats], 0);
        end
        force_valid = 1'b0;
        tick();

        // Reset mid-frame, then a normal frame
        do_load(10, 10, 3, 3);
        force_x = 8'sd16; force_y = -8'sd16;
        force_valid = 1'b1;
        tick(); tick();
        force_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_node("midrst.n0", 0, 0, 0, 0, 0);
        check_node("midrst.n3", 3, 0, 0, 0, 0);
        check_eq("midrst.busy", busy, 0);
        tick();
        check_eq("midrst.ovalid", output_valid, 0);
        force_valid = 1'b1;
        for (int k = 0; k < NN; k++) begin
            // Load attempted mid-run must be ignored
            load_valid = (k == 2);
            if (k == 2) set_load(50, 50, 50, 50);
            tick();
        end
        load_valid = 1'b0;
        check_eq("after.ovalid", output_valid, 1);
        check_node("after.n2", 2, 1, -1, 4, -4);
        check_node("after.n3", 3, 1, -1, 4, -4);
        check_eq("after.overrun_clear", overrun, 0);

        // Fifth beat lands in DONE: dropped and flags overrun
        tick();
        force_valid = 1'b0;
        check_eq("ovr.flag", overrun, 1);
        check_eq("ovr.busy", busy, 0);
        check_eq("ovr.ovalid", output_valid, 0);
        check_node("ovr.n0", 0, 1, -1, 4, -4);
        tick(); tick();
        check_eq("ovr.sticky", overrun, 1);

        // Load + beat same cycle: p=5, v=0, f=4 -> node0 v=1, p=5
        set_load(5, 5, 0, 0);
        force_x = 8'sd4; force_y = 8'sd4;
        load_valid = 1'b1; force_valid = 1'b1;
        tick();
        load_valid = 1'b0; force_valid = 1'b0;
        check_node("lb.n0", 0, 5, 5, 1, 1);
        check_node("lb.n1", 1, 5, 5, 0, 0);
        check_eq("lb.n3py", nodes_out[1][3], 5);
        check_eq("lb.busy", busy, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
